// File: rtl/alu_csr_pkg.sv
// alu_csr_pkg: shared widths, ALU op codes and CSR bit indices for the CSR-driven ALU responder.
package alu_csr_pkg;
    localparam int ALUDATABITS   = 32;
    localparam int ALUOPBITS     = 4;
    localparam int ALUCSRINBITS  = 3;
    localparam int ALUCSROUTBITS = 3;

    localparam logic [ALUOPBITS-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOPBITS-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOPBITS-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUOPBITS-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUOPBITS-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUOPBITS-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALUOPBITS-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUOPBITS-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUOPBITS-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALUOPBITS-1:0] ALU_SLTU = 4'd9;
    localparam logic [ALUOPBITS-1:0] ALU_MUL  = 4'd10;

    localparam int CSR_IN_PROTECT  = 0;
    localparam int CSR_IN_OP1_STB  = 1;
    localparam int CSR_IN_OP2_STB  = 2;
    localparam int CSR_OUT_OP1_RDY = 0;
    localparam int CSR_OUT_OP2_RDY = 1;
    localparam int CSR_OUT_RES_VLD = 2;
endpackage

// File: rtl/alu_compute.sv
// alu_compute: purely combinational decode of the ALU operation on latched operands.
module alu_compute
    import alu_csr_pkg::*;
(
    input  logic [ALUDATABITS-1:0] op1,
    input  logic [ALUDATABITS-1:0] op2,
    input  logic [ALUOPBITS-1:0]   aluop,
    output logic [ALUDATABITS-1:0] result
);
    logic [4:0] shamt;

    assign shamt = op2[4:0];

    always_comb begin
        result = '0;
        case (aluop)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_XOR:  result = op1 ^ op2;
            ALU_SLL:  result = op1 << shamt;
            ALU_SRL:  result = op1 >> shamt;
            ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
            ALU_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
            ALU_SLTU: result = {31'd0, op1 < op2};
            ALU_MUL:  result = op1 * op2;
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/csr_alu_responder.sv
// csr_alu_responder: strobe-handshaked ALU; captures OP1 then OP2/ALUOP, waits LATENCY cycles,
// writes OP3 once protect is low, and holds the result until a protect pulse releases it.
module csr_alu_responder
    import alu_csr_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ALUDATABITS-1:0]   OP1,
    input  logic [ALUDATABITS-1:0]   OP2,
    input  logic [ALUOPBITS-1:0]     ALUOP,
    input  logic [ALUCSRINBITS-1:0]  CSR_ALU_IN,
    output logic [ALUCSROUTBITS-1:0] CSR_ALU_OUT,
    output logic [ALUDATABITS-1:0]   OP3
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ALUCSROUTBITS-1:0] OUT_IDLE = 3'b001;
    localparam logic [ALUCSROUTBITS-1:0] OUT_WAIT = 3'b010;
    localparam logic [ALUCSROUTBITS-1:0] OUT_BUSY = 3'b000;
    localparam logic [ALUCSROUTBITS-1:0] OUT_DONE = 3'b100;

    logic [2:0]               state_q, state_d;
    logic [ALUCSROUTBITS-1:0] out_q, out_d;
    logic [ALUDATABITS-1:0]   op1_q, op1_d, op2_q, op2_d, op3_q, op3_d, result;
    logic [ALUOPBITS-1:0]     aluop_q, aluop_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     seen_q, seen_d, prot;

    assign prot = CSR_ALU_IN[CSR_IN_PROTECT];

    alu_compute u_alu (
        .op1    (op1_q),
        .op2    (op2_q),
        .aluop  (aluop_q),
        .result (result)
    );

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        aluop_d = aluop_q;
        cnt_d   = cnt_q;
        op3_d   = op3_q;
        seen_d  = seen_q;
        case (state_q)
            S_IDLE: if (CSR_ALU_IN[CSR_IN_OP1_STB]) begin
                op1_d   = OP1;
                state_d = S_WAIT;
            end
            S_WAIT: if (CSR_ALU_IN[CSR_IN_OP2_STB]) begin
                op2_d   = OP2;
                aluop_d = ALUOP;
                cnt_d   = 4'(LATENCY - 1);
                state_d = S_EXEC;
            end
            S_EXEC: if (cnt_q == 4'd0) state_d = S_WRITE; else cnt_d = cnt_q - 4'd1;
            S_WRITE: if (!prot) begin
                op3_d   = result;
                state_d = S_DONE;
            end
            // Release needs a protect pulse seen while holding, then protect low.
            S_DONE: if (!prot && seen_q) begin
                seen_d  = 1'b0;
                state_d = S_IDLE;
            end else seen_d = seen_q | prot;
            default: begin
                state_d = S_IDLE;
                op1_d   = '0;
                op2_d   = '0;
                aluop_d = '0;
                cnt_d   = '0;
                op3_d   = '0;
                seen_d  = 1'b0;
            end
        endcase
        out_d = state_d == S_IDLE ? OUT_IDLE :
                state_d == S_WAIT ? OUT_WAIT :
                state_d == S_DONE ? OUT_DONE : OUT_BUSY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            out_q   <= OUT_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            aluop_q <= '0;
            cnt_q   <= '0;
            op3_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            aluop_q <= aluop_d;
            cnt_q   <= cnt_d;
            op3_q   <= op3_d;
            seen_q  <= seen_d;
        end
    end

    assign CSR_ALU_OUT = out_q;
    assign OP3         = op3_q;
endmodule

// File: tb/tb_csr_alu_responder.sv
// tb_csr_alu_responder: directed scenarios plus randomized transactions checked against a reference ALU model.
module tb_csr_alu_responder;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] OP1, OP2;
    logic [3:0]  ALUOP;
    logic [2:0]  CSR_ALU_IN;
    logic [2:0]  CSR_ALU_OUT;
    logic [31:0] OP3;
    int          n_checks = 0;
    int          n_errors = 0;

    csr_alu_responder #(.LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .OP1         (OP1),
        .OP2         (OP2),
        .ALUOP       (ALUOP),
        .CSR_ALU_IN  (CSR_ALU_IN),
        .CSR_ALU_OUT (CSR_ALU_OUT),
        .OP3         (OP3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        longint unsigned p;
        s = b % 32;
        p = longint'(a) * longint'(b);
        case (op)
            4'd0: return a + b;
            4'd1: return a + ~b + 32'd1;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << s;
            4'd6: return a >> s;
            4'd7: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_op1(input logic [31:0] a);
        OP1 = a;
        CSR_ALU_IN = 3'b010;
        step();
        CSR_ALU_IN = 3'b000;
        OP1 = $urandom;
    endtask

    task automatic strobe_op2(input logic [31:0] b, input logic [3:0] op);
        OP2 = b;
        ALUOP = op;
        CSR_ALU_IN = 3'b100;
        step();
        CSR_ALU_IN = 3'b000;
        OP2 = $urandom;
        ALUOP = 4'($urandom);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp);
        int n = 0;
        while (!CSR_ALU_OUT[2] && n < 40) begin
            step();
            n++;
        end
        check({tag, ":latency"}, 32'(n), 32'(LAT + 1));
        check({tag, ":op3"}, OP3, exp);
    endtask

    task automatic release_done(input string tag, input int hold);
        CSR_ALU_IN = 3'b001;
        repeat (hold) step();
        CSR_ALU_IN = 3'b000;
        step();
        check({tag, ":release"}, 32'(CSR_ALU_OUT), 32'b001);
    endtask

    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        strobe_op1(a);
        check({tag, ":wait"}, 32'(CSR_ALU_OUT), 32'b010);
        strobe_op2(b, op);
        wait_done(tag, ref_alu(op, a, b));
        release_done(tag, 1);
    endtask

    initial begin
        reset = 1'b1;
        OP1 = '0;
        OP2 = '0;
        ALUOP = '0;
        CSR_ALU_IN = '0;
        repeat (2) step();
        reset = 1'b0;
        check("reset:out", 32'(CSR_ALU_OUT), 32'b001);
        check("reset:op3", OP3, 32'd0);

        strobe_op1(32'd5);
        strobe_op2(32'd7, 4'd0);
        wait_done("add", 32'd12);
        check("add:out", 32'(CSR_ALU_OUT), 32'b100);
        release_done("add", 1);

        // Protect raised while still in EXEC must hold off the write.
        strobe_op1(32'd3);
        strobe_op2(32'd5, 4'd1);
        CSR_ALU_IN = 3'b001;
        repeat (LAT + 3) step();
        check("prot:out", 32'(CSR_ALU_OUT), 32'b000);
        check("prot:op3", OP3, 32'd12);
        CSR_ALU_IN = 3'b000;
        step();
        check("prot:op3_after", OP3, 32'hFFFF_FFFE);
        check("prot:out_after", 32'(CSR_ALU_OUT), 32'b100);
        step();
        check("prot:hold", 32'(CSR_ALU_OUT), 32'b100);
        release_done("prot", 2);
        txn("sra", 32'h8000_0000, 32'd4, 4'd7);
        check("sra:const", OP3, 32'hF800_0000);

        OP2 = 32'd99;
        CSR_ALU_IN = 3'b100;
        step();
        check("stray:op2_idle", 32'(CSR_ALU_OUT), 32'b001);
        OP1 = 32'd20;
        CSR_ALU_IN = 3'b110;
        step();
        check("stray:both", 32'(CSR_ALU_OUT), 32'b010);
        OP1 = 32'd77;
        CSR_ALU_IN = 3'b010;
        step();
        check("stray:op1_wait", 32'(CSR_ALU_OUT), 32'b010);
        CSR_ALU_IN = 3'b000;
        strobe_op2(32'd22, 4'd0);
        wait_done("stray", 32'd42);
        release_done("stray", 1);

        strobe_op1(32'h0001_0000);
        strobe_op2(32'h0001_0000, 4'd10);
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst:out", 32'(CSR_ALU_OUT), 32'b001);
        check("rst:op3", OP3, 32'd0);
        repeat (LAT + 2) step();
        check("rst:stay", 32'(CSR_ALU_OUT), 32'b001);
        txn("mul", 32'd6, 32'd7, 4'd10);
        check("mul:const", OP3, 32'd42);

        txn("slt", 32'hFFFF_FFFF, 32'd1, 4'd8);
        check("slt:const", OP3, 32'd1);
        txn("sltu", 32'hFFFF_FFFF, 32'd1, 4'd9);
        check("sltu:const", OP3, 32'd0);
        txn("op13", 32'h1234_5678, 32'h9ABC_DEF0, 4'd13);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [3:0] op;
            a = $urandom;
            b = $urandom;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = {1'b1, 31'($urandom)};
            txn($sformatf("rand%0d_op%0d", i, op), a, b, op);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/csr_alu_responder.md
CSR_ALU_RESPONDER -- requirements
Module: csr_alu_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, giving cycles from OP2 capture to result write (range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port OP1  input  32  first operand, sampled only on OP1 strobe.
REQ-005 SHALL have port OP2  input  32  second operand, sampled only on OP2 strobe.
REQ-006 SHALL have port ALUOP  input  4  operation code, sampled with OP2.
REQ-007 SHALL have port CSR_ALU_IN  input  3  [0]=result protect, [1]=OP1 stable strobe, [2]=OP2 stable strobe.
REQ-008 SHALL have port CSR_ALU_OUT  output  3  [0]=OP1 port ready, [1]=OP2 port ready, [2]=result valid.
REQ-009 SHALL have port OP3  output  32  registered result.

Function
REQ-010 SHALL implement states IDLE, WAIT_OP2, EXEC, WRITE, DONE.
REQ-011 SHALL drive CSR_ALU_OUT = 001 in IDLE, 010 in WAIT_OP2, 000 in EXEC/WRITE, 100 in DONE, all registered.
REQ-012 In IDLE, SHALL latch OP1 and go to WAIT_OP2 on the edge where CSR_ALU_IN[1]=1.
REQ-013 In WAIT_OP2, SHALL latch OP2 and ALUOP, load the latency counter with LATENCY-1, and go to EXEC on CSR_ALU_IN[2]=1.
REQ-014 In EXEC, SHALL decrement the counter each cycle and go to WRITE when it is 0.
REQ-015 In WRITE, SHALL update OP3 only when CSR_ALU_IN[0]=0, then go to DONE; while CSR_ALU_IN[0]=1, SHALL stall in WRITE with OP3 unchanged.
REQ-016 In DONE, SHALL hold OP3 and CSR_ALU_OUT[2]=1, set a seen-protect flag when CSR_ALU_IN[0]=1, and go to IDLE on the first cycle CSR_ALU_IN[0]=0 with the flag set.
REQ-017 SHALL ignore strobes outside their owning state: [1] outside IDLE, [2] outside WAIT_OP2.
REQ-018 If [1] and [2] are both high in IDLE, SHALL accept only OP1.
REQ-019 SHALL compute the ALUOP codes as follows.
  - 0=ADD and 1=SUB, both mod 2^32.
  - 2=AND, 3=OR, 4=XOR.
  - 5=SLL, 6=SRL, 7=SRA, each using OP2[4:0] as the shift amount.
  - 8=SLT (signed) and 9=SLTU, both giving result 0 or 1.
  - 10=MUL, giving the low 32 bits.
  - 11..15 SHALL give result 0.
REQ-020 SHALL compute from latched operands only, so input changes after a strobe do not affect the result.
REQ-021 Total latency from the OP2 strobe edge to CSR_ALU_OUT[2]=1 SHALL be LATENCY+1 cycles when protect is low.
REQ-022 An unknown state encoding SHALL return to IDLE with outputs at reset values.

Reset
REQ-023 On reset, SHALL set state IDLE, CSR_ALU_OUT=001, OP3=0, latched OP1/OP2/ALUOP=0, counter=0, and seen-protect flag=0.
REQ-024 Reset asserted in any state, including mid-EXEC or DONE, SHALL abort the operation, with no OP3 write on that edge.

Structure
REQ-025 Package alu_csr_pkg SHALL hold the ALUOP code constants, ALUDATABITS=32, ALUOPBITS=4, ALUCSRINBITS=3, ALUCSROUTBITS=3, and named CSR bit indices.
REQ-026 SHALL place the combinational op decode in sub-module alu_compute (inputs op1, op2, aluop; output result), instantiated once.
REQ-027 The FSM, counter and registers SHALL reside in csr_alu_responder.

Verification
REQ-028 Basic ADD: strobe OP1=5, then OP2=7 with ALUOP=0 and protect=0 -> OP3=12 and OUT=100 exactly LATENCY+1 cycles after the OP2 strobe.
REQ-029 Protect stall: protect=1 before EXEC ends, SUB 3-5 -> OUT stays 000 and OP3 unchanged; after protect drops -> OP3=0xFFFFFFFE and OUT=100 on the next edge.
REQ-030 Release: in DONE, drive protect 1 for 2 cycles then 0 -> return to IDLE with OUT=001; a following SRA 0x80000000>>4 -> 0xF8000000.
REQ-031 Stray strobes: [2] in IDLE, [1] in WAIT_OP2, both [1] and [2] in IDLE -> only OP1 accepted, and state advances one step.
REQ-032 Reset mid-EXEC: reset during MUL 0x10000 x 0x10000 -> OUT=001 and OP3=0, and the next MUL 6x7 -> 42.
REQ-033 Op sweep: SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; code 13 -> 0.
